fir_capture_buffer: RTL
=======================

# fir_capture_buffer

Captures the 16-bit FIR output sample stream into a 32-entry on-chip buffer for readback and checking. It is the sink side of the stimulus path that plays a 32-sample signal table into the FIR filter: the player reads samples from a ROM, and this block writes filtered samples into a RAM. A capture is armed, optionally gated by an amplitude trigger, and runs for exactly DEPTH samples. During the capture the block tracks peak magnitude, and a registered read port exposes the buffer.

## Interface
- DATA_W, 16, sample width, two's complement
- DEPTH, 32, buffer entries; power of two
- ADDR_W, 5, log2(DEPTH)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- sample_in  in  DATA_W  FIR output sample
- sample_valid  in  1  sample_in valid this cycle
- arm  in  1  start-capture pulse
- abort  in  1  cancel capture
- trig_level  in  DATA_W  signed trigger threshold (used only with FIR_CAP_TRIGGER_EN)
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data valid
- busy  out  1  state is WAIT_TRIG or CAPTURE
- done  out  1  capture complete, sticky until next arm or abort
- cap_count  out  ADDR_W+1  samples written in current capture, 0..DEPTH
- peak_abs  out  DATA_W  largest |sample| captured

## Operation
- FSM states are IDLE, WAIT_TRIG, CAPTURE and DONE.
- Reset: state=IDLE; wr_addr=0; done=0; busy=0; cap_count=0; peak_abs=0; rd_data=0; rd_valid=0. Buffer contents are not reset.
- IDLE or DONE with arm=1:
  - clear done, cap_count, peak_abs and wr_addr;
  - go to WAIT_TRIG (macro on) or CAPTURE (macro off).
- arm while in WAIT_TRIG or CAPTURE is ignored.
- WAIT_TRIG: samples are discarded until the first valid sample with signed sample_in >= signed trig_level. That sample is written to entry 0, with cap_count=1, and the state moves to CAPTURE.
- CAPTURE: each valid sample is written at wr_addr, then wr_addr and cap_count increment.
  - The write that makes cap_count reach DEPTH moves the state to DONE and sets done=1.
  - wr_addr wraps DEPTH-1 -> 0.
  - If the trigger sample already completed DEPTH writes (only when DEPTH=1), the state goes directly to DONE.
- peak_abs is updated on every captured sample: peak_abs = max(peak_abs, |s|). |-32768| saturates to 32767.
- abort=1 in any state: go to IDLE, busy=0, done=0. cap_count, peak_abs and buffer contents hold. The sample on that edge is not written.
- abort and arm on the same edge: abort wins and the state ends in IDLE.
- The read port works in every state.
  - rd_en=1 at edge N gives rd_data=mem[rd_addr] and rd_valid=1 after edge N+1; rd_valid is 0 otherwise.
  - A read and a write to the same address on the same edge return the old data (read-before-write).
- sample_valid=0 cycles are stalls: no write and no state change, except arm/abort handling.

## Timing
- Write latency: a sample valid at edge N is in memory after edge N and readable by rd_en at edge N+1.
- Status outputs (done, busy, cap_count, peak_abs) are registered and reflect edge N after edge N.
- Read latency is one cycle, with full throughput of one read per cycle.
- With back-to-back valid samples and macro off, arm at edge A gives done=1 after edge A+DEPTH. The first sample is written at edge A+1.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- Macro: FIR_CAP_TRIGGER_EN.
- Defined: the WAIT_TRIG state and the trig_level comparator are present, and arm enters WAIT_TRIG.
- Undefined: the WAIT_TRIG state is not built, arm enters CAPTURE directly, and trig_level is ignored. The port is kept so the interface is identical in both builds.

## Test plan
- Reset low mid-capture (cap_count=10) -> all outputs 0 and state IDLE immediately; after release, arm restarts at cap_count=0.
- Macro off, arm, then 32 back-to-back samples 0..31 -> done=1 one cycle after the 32nd sample; reads of addresses 0..31 return 0..31 with rd_valid one cycle after rd_en.
- Macro on, trig_level=100, stream 0,50,99,100,101,... -> entry 0 = 100, and the earlier samples are absent.
- Stream includes -32768 and 1200 -> peak_abs=32767; stream max |x|=1200 with no -32768 -> peak_abs=1200.
- abort at cap_count=7 together with arm -> state IDLE, done=0, cap_count stays 7; a later arm clears cap_count to 0.
- sample_valid toggling 1/0 during capture -> exactly 32 writes, no writes on invalid cycles, done after the 32nd valid sample; arm during busy is ignored.

Source files
------------

// File: rtl/fir_capture_buffer.sv
// Capture buffer for the FIR output stream: arm/trigger/capture FSM, peak-magnitude tracker, registered read port.
// Optional amplitude trigger (WAIT_TRIG state) is built only when FIR_CAP_TRIGGER_EN is defined.
module fir_capture_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_sample_in,
  input  logic              i_sample_valid,
  input  logic              i_arm,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_trig_level,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_cap_count,
  output logic [DATA_W-1:0] o_peak_abs
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
`ifdef FIR_CAP_TRIGGER_EN
    S_WAIT_TRIG = 2'd1,
`endif
    S_CAPTURE   = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  state_t              r_state;
  state_t              w_next;
  logic                w_we;
  logic                w_clr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W:0]     r_cap_count;
  logic [DATA_W-1:0]   r_peak_abs;
  logic                r_done;
  logic                r_busy;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   w_abs;
  logic [DATA_W-1:0]   r_mem [DEPTH];

`ifndef FIR_CAP_TRIGGER_EN
  logic w_unused_trig;
  assign w_unused_trig = ^i_trig_level;
`endif

  // |x| with the most negative code saturated to the most positive one
  always_comb begin
    w_abs = i_sample_in;
    if (i_sample_in[DATA_W-1])
      w_abs = (i_sample_in == MOST_NEG) ? MOST_POS : DATA_W'(-i_sample_in);
  end

  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_clr  = 1'b0;
    if (i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_arm) begin
            w_clr = 1'b1;
`ifdef FIR_CAP_TRIGGER_EN
            w_next = S_WAIT_TRIG;
`else
            w_next = S_CAPTURE;
`endif
          end
        end
`ifdef FIR_CAP_TRIGGER_EN
        S_WAIT_TRIG: begin
          if (i_sample_valid && ($signed(i_sample_in) >= $signed(i_trig_level))) begin
            w_we   = 1'b1;
            w_next = (DEPTH == 1) ? S_DONE : S_CAPTURE;
          end
        end
`endif
        S_CAPTURE: begin
          if (i_sample_valid) begin
            w_we = 1'b1;
            if (r_cap_count == CNT_LAST)
              w_next = S_DONE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_wr_addr   <= '0;
      r_cap_count <= '0;
      r_peak_abs  <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE);
      r_busy  <= (w_next != S_IDLE) && (w_next != S_DONE);
      if (w_clr) begin
        r_wr_addr   <= '0;
        r_cap_count <= '0;
        r_peak_abs  <= '0;
      end else if (w_we) begin
        r_wr_addr   <= r_wr_addr + 1'b1;
        r_cap_count <= r_cap_count + 1'b1;
        if (w_abs > r_peak_abs)
          r_peak_abs <= w_abs;
      end
    end
  end

  // Buffer is deliberately unreset so it maps onto plain RAM
  always_ff @(posedge i_clk) begin
    if (w_we)
      r_mem[r_wr_addr] <= i_sample_in;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en)
        r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_cap_count = r_cap_count;
  assign o_peak_abs  = r_peak_abs;

endmodule
